uart_tx_sender: RTL and testbench

Byte-oriented UART transmitter sitting directly downstream of the baud generator in the MMIO UART path. Buffers bytes written by the CPU peripheral bus in a small FIFO, triggers the baud generator once per frame, and shifts one 8N1 frame bit onto the serial line per baud tick. Reports busy, full, and per-frame completion back to the peripheral register file.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 64 ++++++
 rtl/uart_tx_sender.sv | 112 +++++++++++
 tb/tb_uart_tx_sender.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared frame constants and TX state encoding for the UART path.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int   FRAME_BITS = 10;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        SHIFT    = 2'd2,
        WAIT_FIN = 2'd3
    } tx_state_t;

    // 8N1 frame, transmitted from bit 0 upwards
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {STOP_BIT, data, START_BIT};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Small synchronous byte FIFO; occupancy counter drives full/empty.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int               c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL  = (c_ADDR_W + 1)'(FIFO_DEPTH);

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic                w_push;
    logic                w_pop;

    // full/empty reflect the count at the start of the cycle, so a pop never frees space for a same-cycle push
    assign full    = (r_count == c_FULL);
    assign empty   = (r_count == '0);
    assign w_push  = wr_en & ~full;
    assign w_pop   = rd_en & ~empty;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge sysclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sender.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sender
// Purpose  : FIFO-buffered 8N1 transmitter driven by an external baud generator.
// Revision : 1.0
// ============================================================================
module uart_tx_sender
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       fifo_full,
    output logic       overflow,
    output logic       baud_trigger,
    output logic       baud_type,
    input  logic       baud_tick,
    input  logic       baud_status,
    input  logic       baud_finish,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    tx_state_t             r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [3:0]            r_idx;
    logic                  w_pop;
    logic                  w_empty;
    logic [7:0]            w_rd_data;

    assign baud_type = 1'b1;
    assign w_pop     = (r_state == LOAD);

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk  (sysclk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (fifo_full),
        .empty   (w_empty)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_shift      <= '1;
            r_idx        <= '0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            overflow     <= 1'b0;
            baud_trigger <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            overflow     <= wr_en & fifo_full;
            baud_trigger <= 1'b0;
            tx_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    // waiting for baud_status to drop keeps frames from overlapping a still-running generator
                    if (!w_empty && !baud_status) begin
                        r_state      <= LOAD;
                        tx_busy      <= 1'b1;
                        baud_trigger <= 1'b1;
                    end
                end
                LOAD: begin
                    r_shift <= build_frame(w_rd_data);
                    r_idx   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (baud_tick) begin
                        tx    <= r_shift[r_idx];
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == 4'(FRAME_BITS - 1)) begin
                            r_state <= WAIT_FIN;
                        end
                    end
                    // generator abort: the tick above is overridden, the frame is dropped
                    if (baud_finish) begin
                        tx      <= 1'b1;
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                WAIT_FIN: begin
                    tx <= 1'b1;
                    if (baud_finish) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sender
// Purpose  : Scoreboard bench for uart_tx_sender with a behavioural baud generator.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_sender;

    localparam int PERIOD = 16;

    logic       sysclk      = 1'b0;
    logic       reset       = 1'b0;
    logic       wr_en       = 1'b0;
    logic [7:0] wr_data     = 8'h00;
    logic       baud_tick   = 1'b0;
    logic       baud_status = 1'b0;
    logic       baud_finish = 1'b0;
    logic       fifo_full, overflow, baud_trigger, baud_type, tx, tx_busy, tx_done;

    typedef struct {
        logic [9:0] frame;
        int         nbits;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [9:0] cap;
    logic [9:0] mask;
    int         nbits    = 0;
    int         tests    = 0;
    int         fails    = 0;
    int         done_cnt = 0;
    int         ovf_cnt  = 0;
    int         trig_cnt = 0;
    int         viol_cnt = 0;
    bit         park     = 1'b0;
    int         abort_at = 0;
    bit         gen_active = 1'b0;
    int         gen_cnt = 0, gen_ticks = 0, hold = 0;

    always #5 sysclk = ~sysclk;

    uart_tx_sender #(.FIFO_DEPTH(4)) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .baud_trigger (baud_trigger),
        .baud_type    (baud_type),
        .baud_tick    (baud_tick),
        .baud_status  (baud_status),
        .baud_finish  (baud_finish),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Baud generator model: 10 ticks every PERIOD cycles, then finish; optional abort with lingering status
    initial forever begin
        @(negedge sysclk);
        baud_tick   = 1'b0;
        baud_finish = 1'b0;
        if (!reset) begin
            gen_active = 1'b0; hold = 0; gen_cnt = 0; gen_ticks = 0;
        end else if (gen_active) begin
            gen_cnt++;
            if (gen_ticks == 10 || (abort_at != 0 && gen_ticks == abort_at)) begin
                baud_finish = 1'b1;
                gen_active  = 1'b0;
                if (gen_ticks != 10) begin
                    hold     = 6;
                    abort_at = 0;
                end
            end else if (gen_cnt == PERIOD) begin
                gen_cnt   = 0;
                baud_tick = 1'b1;
                gen_ticks++;
            end
        end else if (hold > 0) begin
            hold--;
        end else if (baud_trigger) begin
            gen_active = 1'b1; gen_cnt = 0; gen_ticks = 0;
        end
        baud_status = gen_active || (hold > 0) || park;
    end

    // Monitor: capture line bits after each tick, compare a whole frame on tx_done
    initial forever begin
        @(posedge sysclk);
        #1;
        if (!reset) begin
            nbits = 0;
        end else begin
            if (baud_trigger) begin
                trig_cnt++;
                if (baud_status) viol_cnt++;
            end
            if (overflow) ovf_cnt++;
            if (baud_tick && tx_busy && nbits < 10) begin
                cap[nbits] = tx;
                nbits++;
            end
            if (tx_done) begin
                done_cnt++;
                check("tx_high_at_done", tx, 1);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got frame %0h (%0d bits), expected none", cap, nbits);
                end else begin
                    e    = sb.pop_front();
                    mask = 10'((1 << nbits) - 1);
                    check("frame_bits", nbits, e.nbits);
                    check("frame_data", cap & mask, e.frame & mask);
                end
                nbits = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        @(negedge sysclk);
        wr_en   = 1'b1;
        wr_data = b;
        if (accepted) sb.push_back('{frame: {1'b1, b, 1'b0}, nbits: 10});
    endtask

    task automatic end_write();
        @(negedge sysclk);
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        check("done_timeout", done_cnt >= target, 1);
    endtask

    initial begin
        int d0, o0, t0, n, ticks;
        // Reset values
        repeat (2) @(negedge sysclk);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_full", fifo_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_trig", baud_trigger, 0);
        check("rst_done", tx_done, 0);
        check("baud_type", baud_type, 1);
        reset = 1'b1;
        repeat (2) @(negedge sysclk);

        // Single byte with trigger latency
        push_byte(8'h55, 1);
        end_write();
        check("trig_cycle1", baud_trigger, 0);
        @(negedge sysclk);
        check("trig_cycle2", baud_trigger, 1);
        check("busy_in_load", tx_busy, 1);
        @(negedge sysclk);
        check("trig_pulse_end", baud_trigger, 0);
        wait_done(1, 400);
        repeat (3) @(negedge sysclk);
        check("single_busy_after", tx_busy, 0);
        check("single_done_cnt", done_cnt, 1);

        // Burst of four with the generator held busy so the FIFO fills
        d0 = done_cnt; t0 = trig_cnt;
        park = 1'b1;
        @(negedge sysclk);
        push_byte(8'hA3, 1);
        push_byte(8'h00, 1);
        push_byte(8'hFF, 1);
        push_byte(8'h7E, 1);
        end_write();
        check("burst_full", fifo_full, 1);
        check("burst_no_start", trig_cnt - t0, 0);
        park = 1'b0;
        wait_done(d0 + 4, 1000);
        repeat (3) @(negedge sysclk);
        check("burst_done_cnt", done_cnt - d0, 4);

        // Overflow while a frame is in flight
        d0 = done_cnt; o0 = ovf_cnt;
        push_byte(8'h01, 1);
        end_write();
        repeat (4) @(negedge sysclk);
        push_byte(8'h10, 1);
        push_byte(8'h20, 1);
        push_byte(8'h30, 1);
        push_byte(8'h40, 1);
        push_byte(8'h11, 0);
        push_byte(8'h11, 0);
        end_write();
        check("ovf_full", fifo_full, 1);
        check("ovf_pulses", ovf_cnt - o0, 2);
        wait_done(d0 + 5, 1200);
        repeat (3) @(negedge sysclk);

        // Write landing in the LOAD cycle while full
        d0 = done_cnt;
        park = 1'b1;
        @(negedge sysclk);
        push_byte(8'h81, 1);
        push_byte(8'h42, 1);
        push_byte(8'h24, 1);
        push_byte(8'h18, 1);
        end_write();
        check("load_full_before", fifo_full, 1);
        o0 = ovf_cnt;
        park = 1'b0;
        n = 0;
        while (!baud_trigger && n < 50) begin
            @(negedge sysclk);
            n++;
        end
        check("load_trig_seen", baud_trigger, 1);
        wr_en   = 1'b1;
        wr_data = 8'h22;
        @(negedge sysclk);
        wr_en = 1'b0;
        check("load_ovf_pulse", overflow, 1);
        check("load_occ_3", fifo_full, 0);
        check("load_ovf_cnt", ovf_cnt - o0, 1);
        wait_done(d0 + 4, 1000);
        repeat (3) @(negedge sysclk);

        // Reset in the middle of 0xC3, with a second byte queued
        d0 = done_cnt;
        push_byte(8'hC3, 1);
        push_byte(8'h5A, 1);
        end_write();
        ticks = 0; n = 0;
        while (ticks < 4 && n < 200) begin
            @(posedge sysclk);
            #1;
            if (baud_tick) ticks++;
            n++;
        end
        check("rst_mid_ticks", ticks, 4);
        check("tx_before_reset", tx, 0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", tx_busy, 0);
        sb.delete();
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        t0 = trig_cnt;
        repeat (40) @(negedge sysclk);
        check("rst_fifo_empty", trig_cnt - t0, 0);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_idle_busy", tx_busy, 0);
        check("rst_idle_tx", tx, 1);

        // Generator abort after tick 5, next byte waits for baud_status low
        d0 = done_cnt;
        abort_at = 5;
        @(negedge sysclk);
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        sb.push_back('{frame: {1'b1, 8'h3C, 1'b0}, nbits: 5});
        @(negedge sysclk);
        wr_data = 8'h96;
        sb.push_back('{frame: {1'b1, 8'h96, 1'b0}, nbits: 10});
        @(negedge sysclk);
        wr_en = 1'b0;
        wait_done(d0 + 1, 400);
        check("abort_tx", tx, 1);
        check("abort_idle", tx_busy, 0);
        check("abort_status_held", baud_status, 1);
        wait_done(d0 + 2, 400);
        repeat (3) @(negedge sysclk);
        check("abort_done_cnt", done_cnt - d0, 2);

        check("trig_while_status", viol_cnt, 0);
        check("sb_drained", sb.size(), 0);
        check("total_ovf", ovf_cnt, 3);
        check("total_done", done_cnt, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
